udp_sample_frame_packer: RTL and testbench

//  Ping-pong frame buffer feeding the UDP transmit path. Collects 32-bit IQ/audio samples

---
 rtl/udp_sample_pkg.sv | 27 ++
 rtl/udp_sample_frame_packer_if.sv | 24 ++
 rtl/pingpong_sample_ram.sv | 28 ++
 rtl/udp_sample_frame_packer.sv | 147 ++++++++++++++
 tb/tb_udp_sample_frame_packer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/udp_sample_pkg.sv
// Shared definitions for the UDP sample frame packer: stream FSM encodings, bank ids, byte helpers.
// SEQ_HDR_EN adds the sequence-number header state and its 4 header bytes.
package udp_sample_pkg;
    localparam int   BYTES_PER_WORD = 4;
    localparam logic BANK0          = 1'b0;
    localparam logic BANK1          = 1'b1;

`ifdef SEQ_HDR_EN
    localparam int HDR_BYTES = 4;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_REQ, ST_HDR, ST_STREAM, ST_DONE} stream_state_t;
    localparam stream_state_t ST_AFTER_REQ = ST_HDR;
`else
    localparam int HDR_BYTES = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_REQ, ST_STREAM, ST_DONE} stream_state_t;
    localparam stream_state_t ST_AFTER_REQ = ST_STREAM;
`endif

    // Byte sel of a word, sel 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction
endpackage

// File: rtl/udp_sample_frame_packer_if.sv
// Sample-in / MAC TX RAM write bus of the UDP sample frame packer.
interface udp_sample_frame_packer_if #(parameter int OVF_W = 16) ();
    logic             sample_valid;
    logic [31:0]      sample_data;
    logic             frame_ready;
    logic             frame_pending;
    logic             udp_ram_data_req;
    logic [7:0]       ram_wr_data;
    logic             ram_wr_en;
    logic             write_end;
    logic [15:0]      udp_send_data_length;
    logic [OVF_W-1:0] overflow_cnt;

    modport master (
        input  sample_valid, sample_data, udp_ram_data_req,
        output frame_ready, frame_pending, ram_wr_data, ram_wr_en, write_end,
               udp_send_data_length, overflow_cnt
    );
    modport slave (
        output sample_valid, sample_data, udp_ram_data_req,
        input  frame_ready, frame_pending, ram_wr_data, ram_wr_en, write_end,
               udp_send_data_length, overflow_cnt
    );
endinterface

// File: rtl/pingpong_sample_ram.sv
// Two-bank sample store: simple dual-port RAM, bank 1 located after bank 0, registered read.
module pingpong_sample_ram #(
    parameter int FRAME_WORDS = 100,
    parameter int PTR_W       = $clog2(FRAME_WORDS)
) (
    input  logic             gmii_tx_clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [31:0]      wr_data,
    input  logic             rd_bank,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [31:0]      rd_data
);
    localparam int DEPTH  = 2 * FRAME_WORDS;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wa, ra;

    assign wa = wr_bank ? ADDR_W'(FRAME_WORDS) + ADDR_W'(wr_ptr) : ADDR_W'(wr_ptr);
    assign ra = rd_bank ? ADDR_W'(FRAME_WORDS) + ADDR_W'(rd_ptr) : ADDR_W'(rd_ptr);

    always_ff @(posedge gmii_tx_clk) begin
        if (wr_en) mem[wa] <= wr_data;
        rd_data <= mem[ra];
    end
endmodule

// File: rtl/udp_sample_frame_packer.sv
// Ping-pong frame buffer: fills banks with samples, streams full banks MSB-first as bytes to the MAC.
// Define SEQ_HDR_EN to prefix each frame with a 32-bit sequence number.
module udp_sample_frame_packer
    import udp_sample_pkg::*;
#(
    parameter int FRAME_WORDS = 100,
    parameter int OVF_W       = 16
) (
    input  logic                      gmii_tx_clk,
    input  logic                      rst_n,
    udp_sample_frame_packer_if.master bus
);
    localparam int               PTR_W     = $clog2(FRAME_WORDS);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FRAME_WORDS - 1);
    localparam int               FRAME_LEN = FRAME_WORDS * BYTES_PER_WORD + HDR_BYTES;

    stream_state_t    state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc, rd_addr;
    logic             wr_bank, rd_bank, drop;
    logic [1:0]       bank_full, bank_set, bank_clr;
    logic [1:0]       bsel;
    logic [31:0]      rd_data;
    logic [OVF_W-1:0] ovf_cnt;
    logic             frame_ready_q, wr_en_q, write_end_q;
    logic [7:0]       wr_data_q;
    logic             sample_wr, last_wr, free_vld, other_free, last_byte;
`ifdef SEQ_HDR_EN
    logic [31:0]      seq_num;
`endif

    assign sample_wr  = bus.sample_valid && !drop;
    assign last_wr    = sample_wr && (wr_ptr == LAST_PTR);
    assign free_vld   = (state == ST_DONE);
    // A bank freed on the same edge the fill bank completes counts as free.
    assign other_free = !bank_full[~wr_bank] || (free_vld && rd_bank == ~wr_bank);
    assign bank_set   = {last_wr && wr_bank == BANK1, last_wr && wr_bank == BANK0};
    assign bank_clr   = {free_vld && rd_bank == BANK1, free_vld && rd_bank == BANK0};

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            wr_bank       <= BANK0;
            drop          <= 1'b0;
            bank_full     <= '0;
            frame_ready_q <= 1'b0;
            ovf_cnt       <= '0;
        end else begin
            frame_ready_q <= last_wr;
            bank_full     <= (bank_full | bank_set) & ~bank_clr;
            if (drop) begin
                if (free_vld && rd_bank == ~wr_bank) begin
                    drop    <= 1'b0;
                    wr_bank <= ~wr_bank;
                end
                if (bus.sample_valid && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end else if (sample_wr) begin
                if (last_wr) begin
                    wr_ptr <= '0;
                    if (other_free) wr_bank <= ~wr_bank;
                    else            drop    <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    pingpong_sample_ram #(.FRAME_WORDS(FRAME_WORDS), .PTR_W(PTR_W)) u_ram (
        .gmii_tx_clk (gmii_tx_clk),
        .wr_en       (sample_wr),
        .wr_bank     (wr_bank),
        .wr_ptr      (wr_ptr),
        .wr_data     (bus.sample_data),
        .rd_bank     (rd_bank),
        .rd_ptr      (rd_addr),
        .rd_data     (rd_data)
    );

    assign last_byte  = (bsel == 2'd3) && (rd_ptr == LAST_PTR);
    assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    // One cycle of read latency: present the word the next byte will come from.
    assign rd_addr    = (state == ST_STREAM && bsel == 2'd3) ? rd_ptr_inc : rd_ptr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bank_full[rd_bank]) state_nxt = ST_WAIT_REQ;
            ST_WAIT_REQ: if (bus.udp_ram_data_req) state_nxt = ST_AFTER_REQ;
`ifdef SEQ_HDR_EN
            ST_HDR:      if (bsel == 2'd3) state_nxt = ST_STREAM;
`endif
            ST_STREAM:   if (last_byte) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_bank     <= BANK0;
            rd_ptr      <= '0;
            bsel        <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            write_end_q <= 1'b0;
`ifdef SEQ_HDR_EN
            seq_num     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            write_end_q <= free_vld;
            case (state)
`ifdef SEQ_HDR_EN
                ST_HDR: begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= word_byte(seq_num, bsel);
                    bsel      <= bsel + 1'b1;
                end
`endif
                ST_STREAM: begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= word_byte(rd_data, bsel);
                    bsel      <= bsel + 1'b1;
                    if (bsel == 2'd3) rd_ptr <= rd_ptr_inc;
                end
                ST_DONE: begin
                    rd_bank <= ~rd_bank;
`ifdef SEQ_HDR_EN
                    seq_num <= seq_num + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.frame_ready          = frame_ready_q;
    assign bus.frame_pending        = (state == ST_WAIT_REQ);
    assign bus.ram_wr_en            = wr_en_q;
    assign bus.ram_wr_data          = wr_data_q;
    assign bus.write_end            = write_end_q;
    assign bus.udp_send_data_length = 16'(FRAME_LEN);
    assign bus.overflow_cnt         = ovf_cnt;
endmodule

// File: tb/tb_udp_sample_frame_packer.sv
// Directed bench for udp_sample_frame_packer with FRAME_WORDS=4; honours SEQ_HDR_EN.
module tb_udp_sample_frame_packer;
    localparam int FW = 4;
`ifdef SEQ_HDR_EN
    localparam int EXP_LEN = 20;
`else
    localparam int EXP_LEN = 16;
`endif

    logic gmii_tx_clk = 1'b0;
    logic rst_n       = 1'b0;
    always #5 gmii_tx_clk = ~gmii_tx_clk;

    udp_sample_frame_packer_if #(.OVF_W(16)) bus ();
    udp_sample_frame_packer #(.FRAME_WORDS(FW), .OVF_W(16)) dut (
        .gmii_tx_clk (gmii_tx_clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    int          n_chk   = 0;
    int          n_err   = 0;
    int          fr_cnt  = 0;
    logic [31:0] exp_seq = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
        logic [3:0][31:0] w;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w;
    endfunction

    task automatic do_reset();
        bus.sample_valid     = 1'b0;
        bus.sample_data      = '0;
        bus.udp_ram_data_req = 1'b0;
        rst_n   = 1'b0;
        exp_seq = '0;
        fr_cnt  = 0;
        repeat (2) @(negedge gmii_tx_clk);
        chk("rst_frame_ready", bus.frame_ready, 0);
        chk("rst_pending", bus.frame_pending, 0);
        chk("rst_wr_en", bus.ram_wr_en, 0);
        chk("rst_wr_data", bus.ram_wr_data, 0);
        chk("rst_write_end", bus.write_end, 0);
        chk("rst_overflow", bus.overflow_cnt, 0);
        chk("rst_length", bus.udp_send_data_length, EXP_LEN);
        rst_n = 1'b1;
        @(negedge gmii_tx_clk);
    endtask

    task automatic send(input logic [31:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        @(negedge gmii_tx_clk);
        bus.sample_valid = 1'b0;
        if (bus.frame_ready) fr_cnt++;
    endtask

    task automatic send_frame(input logic [3:0][31:0] w);
        for (int j = 0; j < FW; j++) send(w[j]);
    endtask

    // Requests one frame and checks its byte stream; abort_at pulls reset at that byte index,
    // inject completes the fill bank on the last byte (the edge that frees the streamed bank).
    task automatic do_stream(input logic [3:0][31:0] w, input int abort_at,
                             input logic inject, input logic [31:0] inj_d);
        logic [7:0] eb [$];
        int         n;
`ifdef SEQ_HDR_EN
        for (int k = 3; k >= 0; k--) eb.push_back(exp_seq[8*k +: 8]);
`endif
        for (int j = 0; j < FW; j++)
            for (int k = 3; k >= 0; k--) eb.push_back(w[j][8*k +: 8]);
        n = 0;
        while (!bus.frame_pending && n < 10) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        chk("pending_before_req", bus.frame_pending, 1);
        bus.udp_ram_data_req = 1'b1;
        @(negedge gmii_tx_clk);
        bus.udp_ram_data_req = 1'b0;
        n = 1;
        while (!bus.ram_wr_en && n < 20) begin
            @(negedge gmii_tx_clk);
            n++;
        end
        chk("first_byte_latency", n, 2);
        for (int i = 0; i < EXP_LEN; i++) begin
            chk("wr_en", bus.ram_wr_en, 1);
            chk("wr_data", bus.ram_wr_data, eb[i]);
            chk("write_end_early", bus.write_end, 0);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_wr_en", bus.ram_wr_en, 0);
                chk("abort_wr_data", bus.ram_wr_data, 0);
                return;
            end
            if (inject && i == EXP_LEN - 1) begin
                bus.sample_valid = 1'b1;
                bus.sample_data  = inj_d;
            end
            @(negedge gmii_tx_clk);
            bus.sample_valid = 1'b0;
        end
        chk("write_end", bus.write_end, 1);
        chk("wr_en_after", bus.ram_wr_en, 0);
        chk("wr_data_idle", bus.ram_wr_data, 0);
        if (inject) chk("inject_frame_ready", bus.frame_ready, 1);
        @(negedge gmii_tx_clk);
        chk("write_end_pulse", bus.write_end, 0);
        exp_seq++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0][31:0] a, b, c, d;
        int we_seen, pend_seen;

        // Reset state
        do_reset();

        // Single frame, byte order, latency, write_end
        a = mk(32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677);
        send_frame(a);
        chk("t2_frame_ready_cnt", fr_cnt, 1);
        @(negedge gmii_tx_clk);
        chk("t2_frame_ready_pulse", bus.frame_ready, 0);
        do_stream(a, -1, 1'b0, '0);
        chk("t2_pending_after", bus.frame_pending, 0);

        // Both banks full, drops, then fill resumes in bank 0
        do_reset();
        a = mk(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3);
        b = mk(32'hA4A4A4A4, 32'hA5A5A5A5, 32'hA6A6A6A6, 32'hA7A7A7A7);
        c = mk(32'hB0010203, 32'hB1040506, 32'hB2070809, 32'hB30A0B0C);
        send_frame(a);
        send_frame(b);
        chk("t3_frame_ready_cnt", fr_cnt, 2);
        chk("t3_ovf_before", bus.overflow_cnt, 0);
        send(32'hDEAD0001); send(32'hDEAD0002); send(32'hDEAD0003);
        chk("t3_ovf_drop", bus.overflow_cnt, 3);
        do_stream(a, -1, 1'b0, '0);
        send_frame(c);
        chk("t3_ovf_resumed", bus.overflow_cnt, 3);
        chk("t3_frame_ready_cnt2", fr_cnt, 3);
        do_stream(b, -1, 1'b0, '0);
        do_stream(c, -1, 1'b0, '0);
        chk("t3_ovf_end", bus.overflow_cnt, 3);

        // Bank 1 completes on the edge that frees bank 0
        do_reset();
        a = mk(32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB, 32'hCCCDCECF);
        b = mk(32'hD0D1D2D3, 32'hD4D5D6D7, 32'hD8D9DADB, 32'hDCDDDEDF);
        send_frame(a);
        send(b[0]); send(b[1]); send(b[2]);
        do_stream(a, -1, 1'b1, b[3]);
        chk("t4_ovf_zero", bus.overflow_cnt, 0);
        do_stream(b, -1, 1'b0, '0);
        send(32'hE0E0E0E0);
        chk("t4_ovf_still_zero", bus.overflow_cnt, 0);

        // Reset in the middle of a stream
        do_reset();
        a = mk(32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF);
        send_frame(a);
        do_stream(a, 6, 1'b0, '0);
        repeat (2) @(negedge gmii_tx_clk);
        rst_n     = 1'b1;
        exp_seq   = '0;
        we_seen   = 0;
        pend_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge gmii_tx_clk);
            if (bus.write_end)     we_seen++;
            if (bus.frame_pending) pend_seen++;
        end
        chk("t5_no_write_end", we_seen, 0);
        chk("t5_banks_empty", pend_seen, 0);
        b = mk(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        send_frame(b);
        do_stream(b, -1, 1'b0, '0);

        // Three back-to-back frames (sequence headers 0,1,2 when enabled)
        do_reset();
        a = mk(32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004);
        b = mk(32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004);
        d = mk(32'h30000001, 32'h30000002, 32'h30000003, 32'h30000004);
        send_frame(a);
        do_stream(a, -1, 1'b0, '0);
        send_frame(b);
        do_stream(b, -1, 1'b0, '0);
        send_frame(d);
        do_stream(d, -1, 1'b0, '0);
        chk("t6_ovf", bus.overflow_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
